// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM controller: FSM states,
// ALUControl codes, condition codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_PC        = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Data-processing cmd field (Funct[4:1]) to ALU operation; CMP shares SUB.
  function automatic logic [2:0] dp_alu_op(input logic [3:0] cmd);
    case (cmd)
      4'b0100: dp_alu_op = ALU_ADD;
      4'b0010: dp_alu_op = ALU_SUB;
      4'b1010: dp_alu_op = ALU_SUB;
      4'b0000: dp_alu_op = ALU_AND;
      4'b1100: dp_alu_op = ALU_ORR;
      4'b0001: dp_alu_op = ALU_EOR;
      4'b1101: dp_alu_op = ALU_MOV;
      default: dp_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register with separate NZ/CV write enables, condition evaluation
// against the registered flags, and the per-instruction CondEx latch.
module cond_unit
  import ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_cond,
  input  logic [3:0] i_alu_flags,
  input  logic       i_we_nz,
  input  logic       i_we_cv,
  input  logic       i_latch,
  output logic       o_condex_q
);

  logic [3:0] r_flags;
  logic       r_condex;
  logic       w_condex;

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = ~z;
      COND_CS: cond_eval = cy;
      COND_CC: cond_eval = ~cy;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = ~n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = ~v;
      COND_HI: cond_eval = cy & ~z;
      COND_LS: cond_eval = ~cy | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = ~z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign w_condex = cond_eval(i_cond, r_flags);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags <= RESET_FLAGS;
    end else begin
      if (i_we_nz) r_flags[3:2] <= i_alu_flags[3:2];
      if (i_we_cv) r_flags[1:0] <= i_alu_flags[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_condex <= 1'b0;
    end else if (i_latch) begin
      r_condex <= w_condex;
    end
  end

  assign o_condex_q = r_condex;

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle ARM controller: Moore FSM plus instruction decode driving the
// shared-memory datapath. Define CTRL_BL_EN to enable the BL link write.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int         ALUCTRL_W   = 3,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 LinkWrite,
  output logic [3:0]           State
);

  state_t     r_state;
  state_t     w_next;
  logic       w_condex_q;
  logic [2:0] w_dp_op;
  logic [2:0] w_alu;
  logic       w_pcw, w_irw, w_regw, w_memw, w_linkw, w_adr, w_srca;
  logic [1:0] w_srcb, w_res;
  logic       w_is_cmp, w_pc_dest, w_bl, w_flag_upd, w_we_cv;

`ifdef CTRL_BL_EN
  assign w_bl = Funct[4];
`else
  assign w_bl = 1'b0;
`endif

  assign w_dp_op   = dp_alu_op(Funct[4:1]);
  assign w_is_cmp  = (Funct[4:1] == 4'b1010);
  assign w_pc_dest = (Rd == 4'd15);

  // Flags only change at the end of an executing data-processing S instruction.
  assign w_flag_upd = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI))
                      && Funct[0] && (Op == 2'b00) && w_condex_q;
  assign w_we_cv    = w_flag_upd && ((w_dp_op == ALU_ADD) || (w_dp_op == ALU_SUB));

  cond_unit #(
    .RESET_FLAGS(RESET_FLAGS)
  ) u_cond (
    .clk        (clk),
    .rst        (rst),
    .i_cond     (Cond),
    .i_alu_flags(ALUFlags),
    .i_we_nz    (w_flag_upd),
    .i_we_cv    (w_we_cv),
    .i_latch    (r_state == S_DECODE),
    .o_condex_q (w_condex_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = S_FETCH;
    w_pcw   = 1'b0;
    w_irw   = 1'b0;
    w_regw  = 1'b0;
    w_memw  = 1'b0;
    w_linkw = 1'b0;
    w_adr   = 1'b0;
    w_srca  = 1'b0;
    w_srcb  = SRCB_REG;
    w_res   = RES_ALUOUT;
    w_alu   = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        w_irw  = 1'b1;
        w_pcw  = 1'b1;
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_res  = RES_ALURESULT;
        w_next = S_DECODE;
      end
      S_DECODE: begin
        w_srca = 1'b1;
        w_srcb = SRCB_FOUR;
        w_res  = RES_ALURESULT;
        case (Op)
          2'b01:   w_next = S_MEMADR;
          2'b00:   w_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_srcb = SRCB_IMM;
        w_alu  = Funct[3] ? ALU_ADD : ALU_SUB;
        w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_adr  = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_res  = RES_DATA;
        w_regw = w_condex_q;
        w_pcw  = w_condex_q & w_pc_dest;
        w_next = S_FETCH;
      end
      S_MEMWR: begin
        w_adr  = 1'b1;
        w_memw = w_condex_q;
        w_next = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        w_srcb = (r_state == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
        w_alu  = w_dp_op;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_regw = w_condex_q & ~w_is_cmp;
        w_pcw  = w_condex_q & ~w_is_cmp & w_pc_dest;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        w_srcb  = SRCB_IMM;
        w_pcw   = w_condex_q;
        w_res   = w_bl ? RES_PC : RES_ALURESULT;
        w_regw  = w_bl & w_condex_q;
        w_linkw = w_bl & w_condex_q;
        w_next  = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Write enables are held off while reset is asserted; selects show FETCH.
  assign PCWrite    = w_pcw   & ~rst;
  assign IRWrite    = w_irw   & ~rst;
  assign RegWrite   = w_regw  & ~rst;
  assign MemWrite   = w_memw  & ~rst;
  assign LinkWrite  = w_linkw & ~rst;
  assign AdrSrc     = w_adr;
  assign ALUSrcA    = w_srca;
  assign ALUSrcB    = w_srcb;
  assign ResultSrc  = w_res;
  assign ALUControl = ALUCTRL_W'(w_alu);
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
  assign State      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction expected
// traces generated from instruction class, plus an NZCV/condition model.
module tb_multicycle_controller;
  import ctrl_pkg::*;

  localparam logic [3:0] RST_FLAGS = 4'b0010;

  typedef struct packed {
    state_t     st;
    logic       pcw, irw, rw, mw, adr, sa;
    logic [1:0] sb, rs;
    logic [2:0] alu;
    logic       lw;
    logic [1:0] imm, rsrc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] Cond = 4'd0;
  logic [1:0] Op = 2'd0;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] ALUFlags = 4'd0;
  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, LinkWrite;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] m_flags;
  logic [2:0] alu_of [16];
  exp_t       trace[$];

  multicycle_controller #(.ALUCTRL_W(3), .RESET_FLAGS(RST_FLAGS)) dut (
    .clk(clk), .rst(rst), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .LinkWrite(LinkWrite), .State(State)
  );

  always #5 clk = ~clk;

  function automatic exp_t observe();
    return exp_t'({State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
                   ALUSrcB, ResultSrc, ALUControl, LinkWrite, ImmSrc, RegSrc});
  endfunction

  // ARM condition: even code tests a predicate, odd code is its negation.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      3'd6:    base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic exp_t rec(input state_t st, input logic [1:0] op);
    exp_t r;
    r      = '0;
    r.st   = st;
    r.imm  = op;
    r.rsrc = {op == 2'b01, op == 2'b10};
    return r;
  endfunction

  function automatic void build_trace(input logic [31:0] ins, input logic cx);
    logic [1:0] op;
    logic [5:0] fn;
    logic       pc_dst, bl, nw;
    exp_t       r;
    op     = ins[27:26];
    fn     = ins[25:20];
    pc_dst = (ins[15:12] == 4'hf);
`ifdef CTRL_BL_EN
    bl = fn[4];
`else
    bl = 1'b0;
`endif
    trace.delete();
    r = rec(S_FETCH, op);  r.pcw = 1'b1; r.irw = 1'b1; r.sa = 1'b1; r.sb = 2'b10; r.rs = 2'b10;
    trace.push_back(r);
    r = rec(S_DECODE, op); r.sa = 1'b1; r.sb = 2'b10; r.rs = 2'b10;
    trace.push_back(r);
    if (op == 2'b10) begin
      r = rec(S_BRANCH, op); r.sb = 2'b01; r.pcw = cx;
      r.rs = bl ? 2'b11 : 2'b10; r.rw = bl && cx; r.lw = bl && cx;
      trace.push_back(r);
    end else if (op == 2'b01) begin
      r = rec(S_MEMADR, op); r.sb = 2'b01; r.alu = fn[3] ? 3'b000 : 3'b001;
      trace.push_back(r);
      if (fn[0]) begin
        r = rec(S_MEMRD, op); r.adr = 1'b1; trace.push_back(r);
        r = rec(S_MEMWB, op); r.rs = 2'b01; r.rw = cx; r.pcw = cx && pc_dst; trace.push_back(r);
      end else begin
        r = rec(S_MEMWR, op); r.adr = 1'b1; r.mw = cx; trace.push_back(r);
      end
    end else if (op == 2'b00) begin
      r = rec(fn[5] ? S_EXECUTEI : S_EXECUTER, op);
      r.sb = fn[5] ? 2'b01 : 2'b00; r.alu = alu_of[fn[4:1]];
      trace.push_back(r);
      nw = (fn[4:1] == 4'b1010);
      r = rec(S_ALUWB, op); r.rw = cx && !nw; r.pcw = cx && !nw && pc_dst;
      trace.push_back(r);
    end
  endfunction

  // Runs one instruction (or its first ncyc cycles) from FETCH, checking every cycle.
  task automatic exec_instr(input logic [31:0] ins, input bit rnd, input logic [3:0] fx,
                            input int ncyc, input string tag);
    exp_t       e, obs;
    logic [3:0] af;
    logic       cx;
    bit         did_exec;
    int         n;
    Cond = ins[31:28]; Op = ins[27:26]; Funct = ins[25:20]; Rd = ins[15:12];
    cx = cond_holds(ins[31:28], m_flags);
    build_trace(ins, cx);
    n = (ncyc > 0 && ncyc < trace.size()) ? ncyc : trace.size();
    did_exec = 1'b0;
    af = 4'd0;
    for (int k = 0; k < n; k++) begin
      ALUFlags = rnd ? 4'($urandom_range(0, 15)) : fx;
      @(negedge clk);
      e   = trace[k];
      obs = observe();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s %08h cyc%0d: got %h expected %h", tag, ins, k, obs, e);
      end
      if (e.st == S_EXECUTER || e.st == S_EXECUTEI) begin
        did_exec = 1'b1;
        af = ALUFlags;
      end
      @(posedge clk);
      #1;
    end
    if (did_exec && ins[27:26] == 2'b00 && ins[20] && cx) begin
      if (alu_of[ins[24:21]] == 3'b000 || alu_of[ins[24:21]] == 3'b001) m_flags = af;
      else m_flags[3:2] = af[3:2];
    end
  endtask

  task automatic check_in_reset(input string tag);
    exp_t e, obs;
    e = rec(S_FETCH, Op); e.sa = 1'b1; e.sb = 2'b10; e.rs = 2'b10;
    obs = observe();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    check_in_reset("reset_initial");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_in_reset("reset_held");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_flags = RST_FLAGS;
  endtask

  task automatic test_add();
    exec_instr(32'he2800004, 1'b1, 4'd0, 0, "add_imm");
  endtask

  task automatic test_beq_not_taken();
    exec_instr(32'h0a00003f, 1'b1, 4'd0, 0, "beq_z0");
  endtask

  task automatic test_cmp();
    exec_instr(32'he35100ff, 1'b0, 4'b0100, 0, "cmp_imm");
  endtask

  task automatic test_beq_taken();
    exec_instr(32'h0a00003f, 1'b1, 4'd0, 0, "beq_z1");
    exec_instr(32'heaffffdf, 1'b1, 4'd0, 0, "b_always");
  endtask

  task automatic test_bl();
    exec_instr(32'heb000000, 1'b1, 4'd0, 0, "bl");
  endtask

  task automatic test_ldr_str();
    exec_instr(32'he5901000, 1'b1, 4'd0, 0, "ldr");
    exec_instr(32'he5804000, 1'b1, 4'd0, 0, "str");
    exec_instr(32'he590f000, 1'b1, 4'd0, 0, "ldr_pc");
  endtask

  task automatic test_reset_mid_ldr();
    exec_instr(32'he35100ff, 1'b0, 4'b0100, 0, "cmp_pre_reset");
    exec_instr(32'he5901000, 1'b1, 4'd0, 3, "ldr_abort");
    rst = 1'b1;
    #1;
    check_in_reset("reset_mid_ldr");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_in_reset("reset_mid_held");
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_flags = RST_FLAGS;
    exec_instr(32'h0a00003f, 1'b1, 4'd0, 0, "beq_after_reset");
    exec_instr(32'h2a000000, 1'b1, 4'd0, 0, "bcs_after_reset");
    exec_instr(32'h3a000000, 1'b1, 4'd0, 0, "bcc_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int i = 0; i < 80; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hf;
      if ($urandom_range(0, 2) == 0) ins[31:28] = 4'he;
      if ($urandom_range(0, 2) == 0) begin
        ins[27:26] = 2'b00;
        ins[20]    = 1'b1;
      end
      exec_instr(ins, 1'b1, 4'd0, 0, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) alu_of[i] = 3'b000;
    alu_of[4'b0010] = 3'b001;
    alu_of[4'b1010] = 3'b001;
    alu_of[4'b0000] = 3'b010;
    alu_of[4'b1100] = 3'b011;
    alu_of[4'b0001] = 3'b100;
    alu_of[4'b1101] = 3'b101;
    m_flags = RST_FLAGS;
    test_reset();
    test_add();
    test_beq_not_taken();
    test_cmp();
    test_beq_taken();
    test_bl();
    test_ldr_str();
    test_reset_mid_ldr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multicycle successor to the single-cycle ARM `controller`. It sequences each instruction through a Moore FSM (FETCH/DECODE/EXECUTE/writeback) and keeps a registered NZCV flag file. It latches the condition result per instruction and drives the datapath select and enable lines of the shared-memory multicycle processor. It sits between the instruction register and the multicycle datapath.

## Interface
- `ALUCTRL_W`, default 3: ALUControl width; must be ≥ 3; upper bits zero-padded.
- `RESET_FLAGS`, default 4'b0000: NZCV value loaded on reset.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `Cond` in 4: Instr[31:28].
- `Op` in 2: Instr[27:26].
- `Funct` in 6: Instr[25:20].
- `Rd` in 4: Instr[15:12]; Rd=15 marks a PC write.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU in the current cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`, `AdrSrc`, `ALUSrcA` out 1 each: enables and selects (AdrSrc 0=PC, 1=ALUOut; ALUSrcA 0=RA, 1=PC).
- `ALUSrcB` out 2: 00 reg, 01 ext-imm, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ALUResult, 11 PC.
- `ImmSrc`, `RegSrc` out 2 each: ImmSrc=Op; RegSrc[0]=(Op==10), RegSrc[1]=(Op==01).
- `ALUControl` out ALUCTRL_W: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV (pass B).
- `LinkWrite` out 1: force write address to R14.
- `State` out 4: current FSM state, for debug.

## Operation
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 (unconditional). Next state DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (forms PC+8). CondEx latched at this clock edge. Next state by Op:
  - Op=01: MEMADR.
  - Op=00: EXECUTEI if Funct[5]=1, else EXECUTER.
  - Op=10: BRANCH.
  - Op=11: FETCH, with no writes.
- MEMADR: ALUSrcA=0, ALUSrcB=01; ADD if Funct[3] (U)=1, else SUB. Next state MEMRD if Funct[0] (L)=1, else MEMWR.
- MEMRD: AdrSrc=1. Next state MEMWB. MEMWB: ResultSrc=01, RegWrite=CondEx_q. Next state FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx_q. Next state FETCH.
- EXECUTER/EXECUTEI: ALUSrcA=0, ALUSrcB=00 or 01. ALUControl decoded from Funct[4:1]: 0100 ADD, 0010 SUB, 1010 CMP→SUB, 0000 AND, 1100 ORR, 0001 EOR, 1101 MOV; any other value → ADD. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx_q & ~NoWrite. NoWrite=1 for CMP. Next state FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx_q. Next state FETCH.
- PCWrite is also asserted in MEMWB/ALUWB when RegWrite=1 and Rd=15.
- Flags: written at the end of EXECUTER/EXECUTEI only when Funct[0] (S)=1, Op=00 and CondEx_q=1.
  - ADD, SUB and CMP write all of NZCV.
  - AND, ORR, EOR and MOV write N and Z only.
- CondEx is evaluated from the registered flags. Supported codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL. Code 1111 evaluates false.
- An instruction sees the flags as they were before its own flag update.
- Combinational outputs not listed for a state are 0; ALUControl defaults to ADD.

## Timing
- One state per cycle. Latencies from FETCH entry: B/BL 3 cycles, data-processing 4, STR 4, LDR 5, Op=11 2.
- Reset (asynchronous): state=FETCH, flags=RESET_FLAGS, CondEx_q=0.
- While rst=1: PCWrite, IRWrite, RegWrite, MemWrite and LinkWrite are forced to 0; the other outputs take their FETCH values.
- Reset asserted mid-instruction aborts it; no write occurs. The first FETCH starts on the first edge after rst deasserts.
- Outputs depend only on the state, the latched instruction fields and CondEx_q; they never depend on ALUFlags in the same cycle.

## Configuration
- `CTRL_BL_EN` defined: in BRANCH, when Funct[4] (L)=1, the block asserts LinkWrite=CondEx_q, RegWrite=CondEx_q and ResultSrc=11, so R14 receives the return address (PC+4).
- `CTRL_BL_EN` undefined: the L bit is ignored, BL behaves as B, and LinkWrite is tied to 0.

## Structure
- `ctrl_pkg`: state enum; ALUControl constants; cond-code constants; ResultSrc and ALUSrcB encodings.
- Sub-module `cond_unit`: NZCV register with per-field write enables, CondEx evaluation and the CondEx_q latch.
- The FSM and decode live in the top module.

## Test plan
- e2800004 (ADD r0,r0,#4): states FETCH→DECODE→EXECUTEI→ALUWB; ALUControl=000; RegWrite=1 only in ALUWB; flags unchanged.
- e35100ff (CMP r1,#0xFF) with ALUFlags=0100: ALUControl=001; RegWrite=0 in ALUWB; Z=1 afterwards.
- e5901000 (LDR), then e5804000 (STR): 5-cycle MEMRD/MEMWB path with RegWrite=1; 4-cycle MEMWR path with MemWrite=1 and AdrSrc=1.
- 0a00003f (BEQ):
  - with Z=0: PCWrite=0 in BRANCH.
  - immediately after the CMP above (Z=1): PCWrite=1.
  - eaffffdf (B): PCWrite=1.
- eb000000 (BL):
  - with `CTRL_BL_EN`: LinkWrite=1, RegWrite=1, ResultSrc=11 in BRANCH.
  - without it: LinkWrite=0, RegWrite=0.
- rst pulsed during MEMRD of LDR: no RegWrite or MemWrite occurs; State=FETCH; flags=RESET_FLAGS; normal fetch resumes one edge after release.
